// File: rtl/disp_pkg.sv
// disp_pkg: constants shared between the seven-segment display driver and the
// capture block that reads the scanned bus back.
//   SEG_0..SEG_F  active-low segment patterns, bit6 = a ... bit0 = g
//   SEG_TABLE     the same patterns indexed by hex value
//   AN_D0..AN_D3  active-low one-cold digit enables
//   cap_state_e   capture FSM states
package disp_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  // Element [0] is the rightmost entry of the concatenation, so the index
  // equals the hex value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  typedef enum logic {
    ST_SETTLE,
    ST_HOLD
  } cap_state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational reverse lookup of an active-low segment pattern.
//   seg   in  7  segments a..g (bit6 = a)
//   hex   out 4  decoded value (0 when not recognized)
//   valid out 1  pattern matched one of the 16 table entries
module seg7_decode
  import disp_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       valid
);

  // Table entries are distinct, so at most one iteration matches.
  always_comb begin
    hex   = 4'h0;
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        hex   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_hex_capture.sv
// disp_hex_capture: samples a multiplexed four-digit seven-segment bus, waits
// for each strobe to settle, and decodes the shown digits back to hex.
//   clk         system clock
//   reset       asynchronous active-low reset
//   an_in[3:0]  active-low digit enables
//   sseg_in[7:0] bit7 dp (raw), bits 6..0 segments a..g active-low
//   hex3..hex0  last decoded value per digit
//   dp_out      last captured dp per digit
//   digit_err   last capture of that digit was an unknown pattern
//   frame_done  one-clock pulse when all four digits captured since last pulse
//   scan_lost   high while no capture for 2^TIMEOUT_W-1 clocks
module disp_hex_capture
  import disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT_W     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an_in,
  input  logic [7:0] sseg_in,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic [3:0] digit_err,
  output logic       frame_done,
  output logic       scan_lost
);

  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX = {TIMEOUT_W{1'b1}};

  logic [11:0]          s1, s2, s3;
  logic [7:0]           stab;
  cap_state_e           state, state_next;
  logic                 change, capture, one_cold;
  logic [1:0]           idx;
  logic [3:0]           dig_mask, seen, seen_new;
  logic [3:0]           dec_hex;
  logic                 dec_valid;
  logic [3:0][3:0]      hex_q;
  logic [TIMEOUT_W-1:0] tmo, tmo_next;

  assign change = (s2 != s3);

  seg7_decode u_dec (
    .seg   (s2[6:0]),
    .hex   (dec_hex),
    .valid (dec_valid)
  );

  always_comb begin
    one_cold = 1'b1;
    idx      = 2'd0;
    case (s2[11:8])
      AN_D0:   idx = 2'd0;
      AN_D1:   idx = 2'd1;
      AN_D2:   idx = 2'd2;
      AN_D3:   idx = 2'd3;
      default: one_cold = 1'b0;
    endcase
  end

  // The window closes on the edge where stab would reach STABLE_CYCLES;
  // blank or multi-driven enables still move to HOLD so they are not
  // re-examined until the bus changes.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      ST_SETTLE: if (!change && stab == STAB_LAST) begin
        state_next = ST_HOLD;
        capture    = one_cold;
      end
      ST_HOLD: if (change) state_next = ST_SETTLE;
      default: state_next = ST_SETTLE;
    endcase
  end

  assign dig_mask = 4'b0001 << idx;
  assign seen_new = seen | dig_mask;
  assign tmo_next = capture ? '0 : (tmo == TMO_MAX) ? tmo : tmo + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= '1;
      s2         <= '1;
      s3         <= '1;
      stab       <= '0;
      state      <= ST_SETTLE;
      seen       <= '0;
      tmo        <= '0;
      hex_q      <= '0;
      dp_out     <= '0;
      digit_err  <= '0;
      frame_done <= 1'b0;
      scan_lost  <= 1'b0;
    end else begin
      s1    <= {an_in, sseg_in};
      s2    <= s1;
      s3    <= s2;
      state <= state_next;
      if (change)                stab <= '0;
      else if (stab < STAB_MAX)  stab <= stab + 8'd1;

      tmo       <= tmo_next;
      scan_lost <= (tmo_next == TMO_MAX);

      frame_done <= 1'b0;
      if (capture) begin
        dp_out[idx] <= s2[7];
        if (dec_valid) begin
          hex_q[idx]     <= dec_hex;
          digit_err[idx] <= 1'b0;
        end else begin
          digit_err[idx] <= 1'b1;
        end
        if (seen_new == 4'hF) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_new;
        end
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];

endmodule

// File: tb/tb_disp_hex_capture.sv
// tb_disp_hex_capture: drives scanned-bus strobes, predicts each capture edge
// and its resulting outputs into a scoreboard queue, and compares when due.
module tb_disp_hex_capture;

  localparam int S = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an_in;
  logic [7:0] sseg_in;
  logic [3:0] hex3, hex2, hex1, hex0, dp_out, digit_err;
  logic       frame_done, scan_lost;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fd_count = 0;

  typedef struct {
    int          due;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        frame;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] m_hex;
  logic [3:0]  m_dp, m_err, m_seen;
  logic [11:0] m_prev;

  disp_hex_capture #(.STABLE_CYCLES(S), .TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .an_in(an_in), .sseg_in(sseg_in),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dp_out(dp_out), .digit_err(digit_err),
    .frame_done(frame_done), .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {valid, value}
  function automatic logic [4:0] ref_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: return 5'h10; 7'b1001111: return 5'h11;
      7'b0010010: return 5'h12; 7'b0000110: return 5'h13;
      7'b1001100: return 5'h14; 7'b0100100: return 5'h15;
      7'b0100000: return 5'h16; 7'b0001111: return 5'h17;
      7'b0000000: return 5'h18; 7'b0000100: return 5'h19;
      7'b0001000: return 5'h1A; 7'b1100000: return 5'h1B;
      7'b0110001: return 5'h1C; 7'b1000010: return 5'h1D;
      7'b0110000: return 5'h1E; 7'b0111000: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  function automatic int an_index(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Drive the bus (called right after a negedge) and predict the capture.
  task automatic model_drive(input logic [3:0] an, input logic [7:0] seg, input int n);
    int d;
    logic [4:0] r;
    exp_t e;
    an_in = an;
    sseg_in = seg;
    d = an_index(an);
    if ({an, seg} != m_prev && n >= S + 1 && d >= 0) begin
      r = ref_decode(seg[6:0]);
      m_dp[d] = seg[7];
      if (r[4]) begin
        m_hex[d*4 +: 4] = r[3:0];
        m_err[d] = 1'b0;
      end else begin
        m_err[d] = 1'b1;
      end
      m_seen[d] = 1'b1;
      e.frame = (m_seen == 4'hF);
      if (e.frame) m_seen = 4'h0;
      e.due = cyc + S + 3;
      e.hex = m_hex;
      e.dp  = m_dp;
      e.err = m_err;
      sbq.push_back(e);
    end
    m_prev = {an, seg};
  endtask

  task automatic drive_bus(input logic [3:0] an, input logic [7:0] seg, input int n);
    model_drive(an, seg, n);
    repeat (n) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_count++;
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    m_hex = '0; m_dp = '0; m_err = '0; m_seen = '0;
    m_prev = 12'hFFF;
  endtask

  task automatic apply_reset();
    #3 reset = 1'b0;
    an_in = 4'hF;
    sseg_in = 8'hFF;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard: capture results and frame_done timing at every negedge.
  always @(negedge clk) begin
    logic exp_fd;
    exp_t e;
    exp_fd = 1'b0;
    if (reset === 1'b1) begin
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL sb_missed: capture due at cycle %0d not checked (now %0d)", sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        exp_fd = e.frame;
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || dp_out !== e.dp || digit_err !== e.err) begin
          errors++;
          $display("FAIL sb_capture cyc %0d: hex=%h dp=%b err=%b, required hex=%h dp=%b err=%b",
                   cyc, {hex3, hex2, hex1, hex0}, dp_out, digit_err, e.hex, e.dp, e.err);
        end
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL sb_frame_done cyc %0d: got %b, required %b", cyc, frame_done, exp_fd);
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({hex3, hex2, hex1, hex0, dp_out, digit_err, frame_done, scan_lost} !== 26'h0) begin
      errors++;
      $display("FAIL reset_initial: outputs %h, required 0", {hex3, hex2, hex1, hex0, dp_out, digit_err, frame_done, scan_lost});
    end
    @(negedge clk);
    reset = 1'b1;
    drive_bus(4'b1110, 8'hCF, 30);   // "1" with dp, gives non-zero state
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({hex3, hex2, hex1, hex0, dp_out, digit_err, frame_done, scan_lost} !== 26'h0) begin
      errors++;
      $display("FAIL reset_async: outputs %h, required 0", {hex3, hex2, hex1, hex0, dp_out, digit_err, frame_done, scan_lost});
    end
    an_in = 4'hF;
    sseg_in = 8'hFF;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    fd_count = 0;
    drive_bus(4'hF, 8'hFF, 30);
    checks++;
    if (fd_count != 0 || {hex3, hex2, hex1, hex0, dp_out, digit_err} !== 24'h0) begin
      errors++;
      $display("FAIL reset_blank: frame pulses %0d hex=%h dp=%b err=%b, required none/0",
               fd_count, {hex3, hex2, hex1, hex0}, dp_out, digit_err);
    end
  endtask

  task automatic test_single();
    int c0;
    model_drive(4'b1110, 8'h92, 30);
    c0 = cyc;
    repeat (30) begin
      @(negedge clk);
      if (cyc == c0 + S + 2) begin
        checks++;
        if (hex0 !== 4'h0) begin
          errors++;
          $display("FAIL single_early: hex0=%h one edge early, required 0", hex0);
        end
      end
      if (cyc == c0 + S + 3) begin
        checks++;
        if (hex0 !== 4'h2 || dp_out[0] !== 1'b1 || digit_err[0] !== 1'b0) begin
          errors++;
          $display("FAIL single_capture: hex0=%h dp=%b err=%b, required 2/1/0", hex0, dp_out[0], digit_err[0]);
        end
      end
    end
  endtask

  task automatic test_full_scan();
    apply_reset();
    fd_count = 0;
    for (int p = 0; p < 2; p++) begin
      drive_bus(4'b0111, {p[0], 7'b0001000}, 40);  // A
      drive_bus(4'b1011, 8'h24, 40);               // 5
      drive_bus(4'b1101, 8'h81, 40);               // 0, dp set
      drive_bus(4'b1110, 8'h38, 40);               // F
    end
    checks++;
    if (fd_count != 2) begin
      errors++;
      $display("FAIL full_scan_frames: got %0d pulses, required 2", fd_count);
    end
    checks++;
    if ({hex3, hex2, hex1, hex0} !== 16'hA50F || dp_out !== 4'b1010) begin
      errors++;
      $display("FAIL full_scan_values: hex=%h dp=%b, required A50F/1010", {hex3, hex2, hex1, hex0}, dp_out);
    end
  endtask

  task automatic test_glitch();
    logic saw3;
    saw3 = 1'b0;
    model_drive(4'b1101, 8'h06, 10);   // "3", cut short
    repeat (10) begin
      @(negedge clk);
      if (hex1 === 4'h3) saw3 = 1'b1;
    end
    model_drive(4'b1101, 8'h4C, 40);   // "4"
    repeat (40) begin
      @(negedge clk);
      if (hex1 === 4'h3) saw3 = 1'b1;
    end
    checks++;
    if (saw3 || hex1 !== 4'h4) begin
      errors++;
      $display("FAIL glitch: saw3=%b hex1=%h, required 0/4", saw3, hex1);
    end
  endtask

  task automatic test_invalid();
    drive_bus(4'b1101, 8'h7F, 30);
    checks++;
    if (digit_err[1] !== 1'b1 || hex1 !== 4'h4) begin
      errors++;
      $display("FAIL invalid_pattern: err1=%b hex1=%h, required 1/4", digit_err[1], hex1);
    end
    drive_bus(4'b1101, 8'h0F, 30);
    checks++;
    if (digit_err[1] !== 1'b0 || hex1 !== 4'h7) begin
      errors++;
      $display("FAIL invalid_recover: err1=%b hex1=%h, required 0/7", digit_err[1], hex1);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    repeat (14) @(negedge clk);
    checks++;
    if (scan_lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: scan_lost=%b after 14 clocks, required 0", scan_lost);
    end
    @(negedge clk);
    checks++;
    if (scan_lost !== 1'b1) begin
      errors++;
      $display("FAIL timeout_assert: scan_lost=%b after 15 clocks, required 1", scan_lost);
    end
    model_drive(4'b1011, 8'h80, 40);   // "8"
    repeat (S + 2) @(negedge clk);
    checks++;
    if (scan_lost !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: scan_lost=%b before capture, required 1", scan_lost);
    end
    @(negedge clk);
    checks++;
    if (scan_lost !== 1'b0 || hex2 !== 4'h8) begin
      errors++;
      $display("FAIL timeout_clear: scan_lost=%b hex2=%h on capture, required 0/8", scan_lost, hex2);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    an_in = 4'hF;
    sseg_in = 8'hFF;
    model_reset();
    #2 reset = 1'b0;
    #1;
    test_reset();
    test_single();
    test_full_scan();
    test_glitch();
    test_invalid();
    test_timeout();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected captures left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
